// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle sequencer driving an 8-bit barrel shifter in passes of up to 7 bits
module shift_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [4:0] in_shamt,
  input  logic       in_dir,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] bs_in,
  output logic [2:0] bs_shamt,
  output logic       bs_dir,
  input  logic [7:0] bs_out
);

  localparam logic [4:0] CHUNK_MAX = 5'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] acc;
  logic [4:0] rem;
  logic       dir_q;
  logic [4:0] chunk;
  logic [4:0] rem_next;
  logic       accept;

  assign chunk    = (rem > CHUNK_MAX) ? CHUNK_MAX : rem;
  assign rem_next = rem - chunk;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 8'h00;
      rem   <= 5'd0;
      dir_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          acc   <= in_data;
          rem   <= in_shamt;
          dir_q <= in_dir;
        end
        SHIFT: begin
          acc <= bs_out;
          rem <= rem_next;
        end
        default: ;
      endcase
    end
  end

  // Every pass runs even once acc has cleared, keeping latency a pure function of shamt.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    bs_shamt  = 3'd0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (accept) state_n = (in_shamt != 5'd0) ? SHIFT : DONE;
      end
      SHIFT: begin
        bs_shamt = chunk[2:0];
        if (rem_next == 5'd0) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bs_in  = acc;
  assign bs_dir = dir_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - vector table and scoreboard bench for shift_sequencer with a behavioural shifter
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_shamt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] bs_in;
  logic [2:0] bs_shamt;
  logic       bs_dir;
  logic [7:0] bs_out;

  always #5 clk = ~clk;

  // Stand-in for the combinational barrel shifter.
  assign bs_out = bs_dir ? (bs_in << bs_shamt) : (bs_in >> bs_shamt);

  shift_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bs_in(bs_in), .bs_shamt(bs_shamt), .bs_dir(bs_dir), .bs_out(bs_out)
  );

  typedef struct {
    logic [7:0] data;
    logic [4:0] shamt;
    logic       dir;
    logic [7:0] exp;
    int         passes;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] sb[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    logic [7:0] e;
    if (sb.size() == 0) begin
      check("unexpected_result", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out_data", {24'd0, out_data}, {24'd0, e});
    end
  endtask

  // Accepts one request, tracks the pass sequence against a reference model, then drains the result.
  task automatic run_vec(input vec_t v);
    logic [7:0] macc;
    logic [4:0] mrem;
    logic [4:0] mchunk;
    int         cyc;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = v.data; in_shamt = v.shamt; in_dir = v.dir; out_ready = 1'b1;
    @(posedge clk);
    sb.push_back(v.exp);
    #1;
    in_valid = 1'b0; in_data = ~v.data; in_shamt = ~v.shamt; in_dir = ~v.dir;
    macc = v.data; mrem = v.shamt; cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 40) begin
      mchunk = (mrem > 5'd7) ? 5'd7 : mrem;
      check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      check("bs_shamt", {29'd0, bs_shamt}, {27'd0, mchunk});
      check("bs_in", {24'd0, bs_in}, {24'd0, macc});
      macc = v.dir ? (macc << mchunk) : (macc >> mchunk);
      mrem = mrem - mchunk;
      cyc++;
      @(negedge clk);
    end
    check("pass_count", cyc, v.passes);
    check("done_bs_shamt", {29'd0, bs_shamt}, 32'd0);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    if (out_valid && out_ready) pop_check();
    @(negedge clk);
    check("after_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'hB5, 5'd0,  1'b1, 8'hB5, 0};
    vecs[1]  = '{8'hB5, 5'd3,  1'b1, 8'hA8, 1};
    vecs[2]  = '{8'hFF, 5'd8,  1'b0, 8'h00, 2};
    vecs[3]  = '{8'h01, 5'd31, 1'b1, 8'h00, 5};
    vecs[4]  = '{8'h80, 5'd7,  1'b0, 8'h01, 1};
    vecs[5]  = '{8'h96, 5'd5,  1'b0, 8'h04, 1};
    vecs[6]  = '{8'h3C, 5'd2,  1'b1, 8'hF0, 1};
    vecs[7]  = '{8'hC3, 5'd7,  1'b1, 8'h80, 1};
    vecs[8]  = '{8'h81, 5'd14, 1'b0, 8'h00, 2};
    vecs[9]  = '{8'h5A, 5'd1,  1'b0, 8'h2D, 1};
    vecs[10] = '{8'h01, 5'd22, 1'b1, 8'h00, 4};
    vecs[11] = '{8'hFF, 5'd15, 1'b1, 8'h00, 3};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_shamt = 5'd0; in_dir = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_bs_shamt", {29'd0, bs_shamt}, 32'd0);
    check("rst_bs_dir", {31'd0, bs_dir}, 32'd0);
    check("rst_bs_in", {24'd0, bs_in}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h80; in_shamt = 5'd7; in_dir = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    sb.push_back(8'h01);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_shift_bs_shamt", {29'd0, bs_shamt}, 32'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {24'd0, out_data}, 32'h01);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    pop_check();
    @(negedge clk);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the second SHIFT cycle discards the operation.
    in_valid = 1'b1; in_data = 8'hFF; in_shamt = 5'd20; in_dir = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rm_shift1", {29'd0, bs_shamt}, 32'd7);
    @(negedge clk);
    check("rm_shift2", {29'd0, bs_shamt}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    check("rm_out_valid", {31'd0, out_valid}, 32'd0);
    check("rm_out_data", {24'd0, out_data}, 32'd0);
    check("rm_in_ready_held", {31'd0, in_ready}, 32'd0);
    check("rm_bs_shamt", {29'd0, bs_shamt}, 32'd0);
    check("rm_acc", {24'd0, bs_in}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rm_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rm_no_stale", {31'd0, out_valid}, 32'd0);
    end

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
